// File: rtl/result_collector_if.sv
// Result collector bus: bfm result strobes in, batch handshake out.
//   done_i/res_i    : one-cycle result strobe and value
//   flush_i         : request to close a partial batch
//   batch_valid_o   : batch held, awaiting transfer
//   batch_ready_i   : consumer accepts the held batch
//   batch_data_o    : packed items, item k at [k*RES_WIDTH +: RES_WIDTH]
//   count_o         : valid items in current/held batch
//   drop_cnt_o      : saturating count of results lost in HOLD
//   checksum_o      : running 32-bit sum (only with RESULT_CHECKSUM_EN)
// Modports: slave (collector side), master (bfm/consumer side).
interface result_collector_if #(
  parameter int unsigned NUM       = 100,
  parameter int unsigned RES_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
);
  localparam int unsigned DATA_W = NUM * RES_WIDTH;

  logic                 done_i;
  logic [RES_WIDTH-1:0] res_i;
  logic                 flush_i;
  logic                 batch_valid_o;
  logic                 batch_ready_i;
  logic [DATA_W-1:0]    batch_data_o;
  logic [CNT_WIDTH-1:0] count_o;
  logic [15:0]          drop_cnt_o;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0]          checksum_o;
`endif

  modport slave (
    input  done_i, res_i, flush_i, batch_ready_i,
    output
`ifdef RESULT_CHECKSUM_EN
           checksum_o,
`endif
           batch_valid_o, batch_data_o, count_o, drop_cnt_o
  );

  modport master (
    output done_i, res_i, flush_i, batch_ready_i,
    input
`ifdef RESULT_CHECKSUM_EN
           checksum_o,
`endif
           batch_valid_o, batch_data_o, count_o, drop_cnt_o
  );
endinterface

// File: rtl/result_collector.sv
// result_collector: packs NUM bfm results into one batch and hands it to the
// consumer with a valid/ready handshake.
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : synchronous active-low reset
//   bus      : result_collector_if.slave (result strobe in, batch out)
// Optional feature: define RESULT_CHECKSUM_EN to add checksum_o, a modulo-2^32
// sum of the stored results of the current/held batch.
module result_collector #(
  parameter int unsigned NUM       = 100,
  parameter int unsigned RES_WIDTH = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  result_collector_if.slave bus
);
  localparam int unsigned DROP_W = 16;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t                         state_q, state_d;
  logic [NUM-1:0][RES_WIDTH-1:0]  items_q, items_d;
  logic [CNT_WIDTH-1:0]           count_q, count_d;
  logic [DROP_W-1:0]              drop_q, drop_d;
  logic                           valid_q, valid_d;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0]                    sum_q, sum_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= FILL;
      items_q <= '0;
      count_q <= '0;
      drop_q  <= '0;
      valid_q <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      items_q <= items_d;
      count_q <= count_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
`ifdef RESULT_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    items_d = items_q;
    count_d = count_q;
    drop_d  = drop_q;
`ifdef RESULT_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      FILL: begin
        if (bus.done_i) begin
          // Decoded write keeps the index compare at count width.
          for (int unsigned k = 0; k < NUM; k++) begin
            if (CNT_WIDTH'(k) == count_q) items_d[k] = bus.res_i;
          end
          count_d = count_q + CNT_WIDTH'(1);
`ifdef RESULT_CHECKSUM_EN
          sum_d   = sum_q + 32'(bus.res_i);
`endif
        end
        // A same-cycle done_i counts, so flush on an empty batch still closes it.
        if ((count_d == CNT_WIDTH'(NUM)) ||
            (bus.flush_i && (count_d != '0))) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.batch_ready_i) begin
          // Transfer: clear the batch; a same-cycle result seeds the next one.
          state_d = FILL;
          items_d = '0;
          count_d = '0;
`ifdef RESULT_CHECKSUM_EN
          sum_d   = '0;
`endif
          if (bus.done_i) begin
            items_d[0] = bus.res_i;
            count_d    = CNT_WIDTH'(1);
`ifdef RESULT_CHECKSUM_EN
            sum_d      = 32'(bus.res_i);
`endif
          end
        end else if (bus.done_i && (drop_q != '1)) begin
          drop_d = drop_q + DROP_W'(1);
        end
      end
      default: state_d = FILL;
    endcase
    valid_d = (state_d == HOLD);
  end

  assign bus.batch_valid_o = valid_q;
  assign bus.batch_data_o  = items_q;
  assign bus.count_o       = count_q;
  assign bus.drop_cnt_o    = drop_q;
`ifdef RESULT_CHECKSUM_EN
  assign bus.checksum_o    = sum_q;
`endif
endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: directed scenarios followed by
// randomized traffic, checked every cycle against a queue-based batch model.
module tb_result_collector;
  localparam int unsigned NUM       = 100;
  localparam int unsigned RES_WIDTH = 16;
  localparam int unsigned CNT_WIDTH = 8;
  localparam int unsigned DATA_W    = NUM * RES_WIDTH;

  logic clk;
  logic rst_n;

  result_collector_if #(.NUM(NUM), .RES_WIDTH(RES_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  result_collector #(.NUM(NUM), .RES_WIDTH(RES_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the batch is a queue of results; holding marks a full/closed batch.
  int          cur[$];
  bit          m_hold;
  int          m_drop;
  logic [31:0] m_sum;

  task automatic model_edge(input logic d, input logic [15:0] r, input logic f,
                            input logic rdy, input logic rst);
    if (!rst) begin
      cur.delete();
      m_hold = 1'b0;
      m_drop = 0;
      m_sum  = '0;
    end else if (m_hold) begin
      if (rdy) begin
        cur.delete();
        m_hold = 1'b0;
        m_sum  = '0;
        if (d) begin
          cur.push_back(int'(r));
          m_sum = 32'(r);
        end
      end else if (d && m_drop < 65535) begin
        m_drop++;
      end
    end else begin
      if (d) begin
        cur.push_back(int'(r));
        m_sum = m_sum + 32'(r);
      end
      if (cur.size() == NUM || (f && cur.size() > 0)) m_hold = 1'b1;
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_data();
    logic [DATA_W-1:0] v;
    v = '0;
    foreach (cur[k]) v[k*RES_WIDTH +: RES_WIDTH] = RES_WIDTH'(cur[k]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag);
    logic [DATA_W-1:0] e;
    logic [DATA_W-1:0] o;
    e = exp_data();
    o = bus.batch_data_o;
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      for (int k = 0; k < int'(NUM); k++) begin
        if (o[k*RES_WIDTH +: RES_WIDTH] !== e[k*RES_WIDTH +: RES_WIDTH]) begin
          $error("FAIL %s item=%0d observed=%0h expected=%0h", tag, k,
                 o[k*RES_WIDTH +: RES_WIDTH], e[k*RES_WIDTH +: RES_WIDTH]);
          break;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_valid"}, 32'(bus.batch_valid_o), 32'(m_hold));
    check({tag, "_count"}, 32'(bus.count_o), 32'(cur.size()));
    check({tag, "_drop"},  32'(bus.drop_cnt_o), 32'(m_drop));
    check_data({tag, "_data"});
`ifdef RESULT_CHECKSUM_EN
    check({tag, "_sum"}, bus.checksum_o, m_sum);
`endif
  endtask

  // One clock: drive inputs, advance model at the edge, check #1 after it.
  task automatic step(input logic d, input logic [15:0] r, input logic f,
                      input logic rdy, input logic rst, input bit chk, input string tag);
    bus.done_i        = d;
    bus.res_i         = r;
    bus.flush_i       = f;
    bus.batch_ready_i = rdy;
    rst_n             = rst;
    @(posedge clk);
    model_edge(d, r, f, rdy, rst);
    #1;
    if (chk) check_all(tag);
  endtask

  initial begin
    bus.done_i = 1'b0; bus.res_i = '0; bus.flush_i = 1'b0; bus.batch_ready_i = 1'b0;
    rst_n = 1'b0;
    cur.delete(); m_hold = 1'b0; m_drop = 0; m_sum = '0;

    // Reset values.
    step(0, 16'h0, 0, 0, 0, 1, "rst0");
    step(0, 16'h0, 0, 0, 0, 1, "rst1");
    check("rst_count_zero", 32'(bus.count_o), 32'd0);
    check("rst_valid_zero", 32'(bus.batch_valid_o), 32'd0);

    // Full batch of k = 0..99.
    for (int k = 0; k < int'(NUM); k++) step(1, 16'(k), 0, 0, 1, 1, "fill");
    check("full_valid", 32'(bus.batch_valid_o), 32'd1);
    check("full_count", 32'(bus.count_o), 32'd100);
    check("full_item0",  32'(bus.batch_data_o[0*RES_WIDTH +: RES_WIDTH]), 32'd0);
    check("full_item57", 32'(bus.batch_data_o[57*RES_WIDTH +: RES_WIDTH]), 32'd57);
    check("full_item99", 32'(bus.batch_data_o[99*RES_WIDTH +: RES_WIDTH]), 32'd99);
`ifdef RESULT_CHECKSUM_EN
    check("full_sum", bus.checksum_o, 32'd4950);
`endif

    // Held with ready low: five drops, contents frozen.
    for (int k = 0; k < 5; k++) step(1, 16'hDEAD, 1, 0, 1, 1, "hold_drop");
    check("drop5", 32'(bus.drop_cnt_o), 32'd5);
    check("hold_item42", 32'(bus.batch_data_o[42*RES_WIDTH +: RES_WIDTH]), 32'd42);

    // Transfer with a same-cycle result.
    step(1, 16'hBEEF, 0, 1, 1, 1, "xfer_beef");
    check("beef_count", 32'(bus.count_o), 32'd1);
    check("beef_item0", 32'(bus.batch_data_o[0 +: RES_WIDTH]), 32'hBEEF);
    check("beef_fill",  32'(bus.batch_valid_o), 32'd0);

    // Close and drain that one-item batch, then flush on empty.
    step(0, 16'h0, 1, 0, 1, 1, "flush1");
    step(0, 16'h0, 0, 1, 1, 1, "drain1");
    step(0, 16'h0, 1, 0, 1, 1, "flush_empty");
    check("flush_empty_valid", 32'(bus.batch_valid_o), 32'd0);
    step(0, 16'h0, 0, 0, 1, 1, "flush_empty2");

    // Three results then flush.
    step(1, 16'h1111, 0, 0, 1, 1, "p3a");
    step(1, 16'h2222, 0, 0, 1, 1, "p3b");
    step(1, 16'h3333, 0, 0, 1, 1, "p3c");
    step(0, 16'h0, 1, 0, 1, 1, "p3flush");
    check("p3_count", 32'(bus.count_o), 32'd3);
    check("p3_item2", 32'(bus.batch_data_o[2*RES_WIDTH +: RES_WIDTH]), 32'h3333);
    check("p3_item3", 32'(bus.batch_data_o[3*RES_WIDTH +: RES_WIDTH]), 32'h0);
    step(0, 16'h0, 0, 1, 1, 1, "p3xfer");
    check("p3_after_count", 32'(bus.count_o), 32'd0);

    // Flush in the same cycle as the first result of an empty batch.
    step(1, 16'h5A5A, 1, 0, 1, 1, "flush_done_empty");
    check("fde_valid", 32'(bus.batch_valid_o), 32'd1);

    // Drop counter saturation, then transfer.
    for (int k = 0; k < 65540; k++) step(1, 16'(k), 0, 0, 1, 0, "sat");
    step(1, 16'h0, 0, 0, 1, 1, "sat_end");
    check("drop_sat", 32'(bus.drop_cnt_o), 32'h0000FFFF);
    step(0, 16'h0, 0, 1, 1, 1, "sat_xfer");

    // Reset while holding discards the batch.
    for (int k = 0; k < 10; k++) step(1, 16'($urandom), 0, 0, 1, 1, "pre_rst");
    step(0, 16'h0, 1, 0, 1, 1, "pre_rst_flush");
    step(1, 16'h7777, 0, 1, 0, 1, "rst_hold");
    check("rst_hold_valid", 32'(bus.batch_valid_o), 32'd0);
    check("rst_hold_count", 32'(bus.count_o), 32'd0);
    check("rst_hold_drop",  32'(bus.drop_cnt_o), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic d, f, rdy, rst;
      d   = ($urandom_range(99, 0) < 70);
      f   = ($urandom_range(99, 0) < 4);
      rdy = ($urandom_range(99, 0) < 30);
      rst = ($urandom_range(999, 0) != 0);
      step(d, 16'($urandom), f, rdy, rst, 1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Receive-side counterpart of the stimulus driver in the DPI array testbench. It samples each completed operation result (`done_i`/`res_i`) from the bfm, packs NUM results into one packed array, and presents the full or flushed batch to the DPI-C result export through a valid/ready handshake. It sits between the bfm result outputs and the testbench process that calls the software checker once per batch.

## Interface
- NUM, 100, results per batch.
- RES_WIDTH, 16, width of one result item.
- CNT_WIDTH, 8, width of `count_o`; must satisfy 2^CNT_WIDTH > NUM.
- clk_i  input  1  clock; all logic on its rising edge.
- reset_i  input  1  reset, synchronous and active-low.
- done_i  input  1  one-cycle strobe from the bfm; `res_i` is valid in the same cycle.
- res_i  input  RES_WIDTH  result value.
- flush_i  input  1  one-cycle request to close a partial batch.
- batch_valid_o  output  1  a batch is held and ready for transfer.
- batch_ready_i  input  1  the consumer accepts the batch.
- batch_data_o  output  NUM*RES_WIDTH  packed results.
  - Item k occupies bits [k*RES_WIDTH +: RES_WIDTH].
  - Unfilled items read as 0.
- count_o  output  CNT_WIDTH  number of valid items in the current or held batch.
- drop_cnt_o  output  16  results lost while in HOLD; saturates at 16'hFFFF.

## Operation
- Two states, FILL and HOLD. Reset state is FILL.
- FILL:
  - On `done_i`, write `res_i` into item `count_o`, then increment `count_o`.
  - If that write makes `count_o`==NUM, go to HOLD.
  - On `flush_i` with `count_o`>0, go to HOLD. A `done_i` in the same cycle is stored first and is included in the batch.
  - On `flush_i` with `count_o`==0 and no `done_i`, nothing happens.
- HOLD:
  - `batch_valid_o`=1. `batch_data_o` and `count_o` are frozen.
  - `done_i` is dropped and `drop_cnt_o` increments.
  - `flush_i` is ignored.
- Transfer occurs on a rising edge with `batch_valid_o` && `batch_ready_i`. At that edge:
  - Clear all items to 0.
  - Set `count_o` to 0.
  - Return to FILL.
- A `done_i` in the transfer cycle is not dropped. It becomes item 0 of the next batch and `count_o`=1; the write wins over the clear.
- Arithmetic:
  - `count_o` never exceeds NUM.
  - `drop_cnt_o` never wraps.
  - Only reset clears `drop_cnt_o`.
- Reset while in HOLD discards the held batch without a transfer.

## Timing
- Reset values: `batch_valid_o`=0, `batch_data_o`=0, `count_o`=0, `drop_cnt_o`=0; state FILL.
- Each stored item is visible on `batch_data_o` and `count_o` one cycle after its `done_i` edge.
- `batch_valid_o` rises one cycle after the edge that completed the batch (NUM-th `done_i`, or `flush_i`).
- `batch_valid_o` falls one cycle after the transfer edge.
- Minimum HOLD duration is 1 cycle. `batch_ready_i` may be high in advance; the transfer then happens on the first HOLD edge.
- The consumer must sample `batch_data_o` at the transfer edge.
- Back-to-back `done_i` on every cycle is supported in FILL with no loss.
- No combinational path exists from any input to any output.

## Configuration
- `RESULT_CHECKSUM_EN` defined:
  - Adds output `checksum_o` [31:0], reset 0.
  - In FILL, each stored result is added modulo 2^32 to the running sum.
  - The sum is frozen with the batch in HOLD.
  - It is cleared at the transfer edge. A `done_i` in the transfer cycle seeds the new sum with its `res_i`.
- `RESULT_CHECKSUM_EN` not defined: no `checksum_o` port and no adder logic. All other behaviour is identical.

## Test plan
- Reset, then 100 `done_i` with `res_i`=k for k=0..99:
  - `batch_valid_o`=1 one cycle after the 100th strobe.
  - Item k==k and `count_o`=100.
  - Checksum=4950 when enabled.
- 3 results (0x1111, 0x2222, 0x3333), then `flush_i`:
  - HOLD with `count_o`=3 and items 3..99 equal to 0.
  - After the transfer, `batch_data_o`=0 and `count_o`=0.
- Full batch held with `batch_ready_i`=0 while 5 `done_i` arrive: `drop_cnt_o`=5 and the batch contents are unchanged.
- `done_i` with `res_i`=0xBEEF in the same cycle as the transfer: next cycle `count_o`=1, item 0=0xBEEF, state FILL.
- `reset_i`=0 for one cycle while in HOLD: next cycle all outputs are at their reset values, and no transfer occurred.
- `flush_i` with `count_o`=0: `batch_valid_o` stays 0 and state stays FILL.
